// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - pipelined pre-add/multiply/post-add MAC slice with auto-dump accumulator
module dsp_mac_pipe #(
    parameter int AW       = 18,
    parameter int PW       = 48,
    parameter int IN_REGS  = 2,
    parameter int MREG     = 1,
    parameter int ACC_LEN  = 0,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          CE,
    input  logic          in_valid,
    input  logic [7:0]    opmode,
    input  logic [AW-1:0] A,
    input  logic [AW-1:0] B,
    input  logic [AW-1:0] D,
    input  logic [PW-1:0] C,
    input  logic [PW-1:0] PCIN,
    input  logic          CARRYIN,
    output logic [PW-1:0] P,
    output logic [PW-1:0] PCOUT,
    output logic          out_valid,
    output logic          acc_done,
    output logic          CARRYOUT,
    output logic          OVERFLOW
);

    if (2 * AW > PW) begin : g_bad_pw
        $error("dsp_mac_pipe: 2*AW must not exceed PW");
    end
    if (IN_REGS < 1 || IN_REGS > 3) begin : g_bad_in_regs
        $error("dsp_mac_pipe: IN_REGS must be 1..3");
    end

    localparam int SW = 1 + 8 + 3 * AW + PW;
    localparam int QW = 1 + 8 + PW + 2 * AW + PW;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((ACC_LEN > 0) ? ACC_LEN - 1 : 0);
    localparam logic [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

    logic unused_carryin;
    assign unused_carryin = CARRYIN;

    // Stage 0 sits in the low SW bits; every CE shift moves all stages up by one slot.
    logic [IN_REGS*SW-1:0] pipe;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pipe <= '0;
        end else if (CE) begin
            pipe <= (IN_REGS*SW)'({pipe, in_valid, opmode, A, B, D, C});
        end
    end

    logic          pa_valid;
    logic [7:0]    pa_op;
    logic [AW-1:0] pa_a, pa_b, pa_d;
    logic [PW-1:0] pa_c;
    assign {pa_valid, pa_op, pa_a, pa_b, pa_d, pa_c} = pipe[IN_REGS*SW-1 -: SW];

    logic [AW-1:0] b_pre;
    always_comb begin
        b_pre = pa_b;
        if (pa_op[4]) begin
            b_pre = pa_op[6] ? pa_d - pa_b : pa_d + pa_b;
        end
    end

    logic signed [2*AW-1:0] prod;
    logic        [PW-1:0]   m_ext;
    assign prod  = (2*AW)'($signed(pa_a)) * (2*AW)'($signed(b_pre));
    assign m_ext = PW'(prod);

    logic [QW-1:0] m_in, m_q;
    assign m_in = {pa_valid, pa_op, m_ext, pa_a, b_pre, pa_c};

    if (MREG != 0) begin : g_mreg
        always_ff @(posedge clk or posedge RST) begin
            if (RST) begin
                m_q <= '0;
            end else if (CE) begin
                m_q <= m_in;
            end
        end
    end else begin : g_mcomb
        assign m_q = m_in;
    end

    logic            q_valid;
    logic [7:0]      q_op;
    logic [PW-1:0]   q_m, q_c;
    logic [2*AW-1:0] q_ab;
    assign {q_valid, q_op, q_m, q_ab, q_c} = m_q;

    // The first sample of each block sees zero feedback instead of the dumped result.
    logic [CW-1:0] cnt;
    logic          restart, last;
    logic [PW-1:0] fb;
    assign restart = (ACC_LEN > 0) && (cnt == '0);
    assign last    = (ACC_LEN > 0) && (cnt == CNT_LAST);
    assign fb      = restart ? '0 : P;

    logic [PW-1:0] x_v, z_v;
    always_comb begin
        x_v = '0;
        case (q_op[1:0])
            2'b01:   x_v = q_m;
            2'b10:   x_v = fb;
            2'b11:   x_v = PW'(q_ab);
            default: x_v = '0;
        endcase
        z_v = '0;
        case (q_op[3:2])
            2'b01:   z_v = PCIN;
            2'b10:   z_v = fb;
            2'b11:   z_v = q_c;
            default: z_v = '0;
        endcase
    end

    logic [PW:0]   cin_w, zs, xs, zu, xu, s_sum, u_sum;
    logic          ovf;
    logic [PW-1:0] p_next;
    assign cin_w = (PW+1)'(q_op[5]);
    assign zs    = {z_v[PW-1], z_v};
    assign xs    = {x_v[PW-1], x_v};
    assign zu    = {1'b0, z_v};
    assign xu    = {1'b0, x_v};
    assign s_sum = q_op[7] ? zs - (xs + cin_w) : zs + xs + cin_w;
    assign u_sum = q_op[7] ? zu - (xu + cin_w) : zu + xu + cin_w;
    assign ovf   = s_sum[PW] ^ s_sum[PW-1];

    always_comb begin
        p_next = s_sum[PW-1:0];
        if (SATURATE != 0 && ovf) begin
            p_next = s_sum[PW] ? P_MIN : P_MAX;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            P         <= '0;
            out_valid <= 1'b0;
            acc_done  <= 1'b0;
            CARRYOUT  <= 1'b0;
            OVERFLOW  <= 1'b0;
            cnt       <= '0;
        end else if (CE) begin
            out_valid <= q_valid;
            acc_done  <= q_valid && last;
            if (q_valid) begin
                P        <= p_next;
                CARRYOUT <= u_sum[PW];
                OVERFLOW <= ovf;
                if (ACC_LEN > 0) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                end
            end
        end
    end

    assign PCOUT = P;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - three configurations of dsp_mac_pipe against an arithmetic reference model
module tb_dsp_mac_pipe;

    localparam int NI = 3;
    localparam longint MAXV   = 64'h0000_7FFF_FFFF_FFFF;
    localparam longint MINV   = 64'hFFFF_8000_0000_0000;
    localparam longint MASK48 = 64'h0000_FFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, in_valid = 1'b0, carryin = 1'b0;
    logic [7:0]  opmode = '0;
    logic [17:0] a = '0, b = '0, d = '0;
    logic [47:0] c = '0, pcin = '0;
    logic [47:0] p_o [NI];
    logic [47:0] pc_o [NI];
    logic        ov_o [NI], ad_o [NI], co_o [NI], of_o [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsp_mac_pipe #(.AW(18), .PW(48), .IN_REGS(2), .MREG(1), .ACC_LEN(0), .SATURATE(0)) u0 (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(in_valid), .opmode(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .P(p_o[0]), .PCOUT(pc_o[0]), .out_valid(ov_o[0]), .acc_done(ad_o[0]),
        .CARRYOUT(co_o[0]), .OVERFLOW(of_o[0]));

    dsp_mac_pipe #(.AW(18), .PW(48), .IN_REGS(2), .MREG(1), .ACC_LEN(4), .SATURATE(1)) u1 (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(in_valid), .opmode(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .P(p_o[1]), .PCOUT(pc_o[1]), .out_valid(ov_o[1]), .acc_done(ad_o[1]),
        .CARRYOUT(co_o[1]), .OVERFLOW(of_o[1]));

    dsp_mac_pipe #(.AW(18), .PW(48), .IN_REGS(1), .MREG(0), .ACC_LEN(1), .SATURATE(0)) u2 (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(in_valid), .opmode(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .P(p_o[2]), .PCOUT(pc_o[2]), .out_valid(ov_o[2]), .acc_done(ad_o[2]),
        .CARRYOUT(co_o[2]), .OVERFLOW(of_o[2]));

    function automatic int lat_of(int i);
        return (i == 2) ? 2 : 4;
    endfunction
    function automatic int acc_of(int i);
        return (i == 0) ? 0 : ((i == 1) ? 4 : 1);
    endfunction
    function automatic int sat_of(int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic longint sx18(logic [17:0] v);
        return longint'($signed(v));
    endfunction
    function automatic longint sx48(logic [47:0] v);
        return longint'($signed(v));
    endfunction
    function automatic longint wrap18(longint v);
        longint t;
        t = v & 64'h3FFFF;
        if (t >= 64'sd131072) t = t - 64'sd262144;
        return t;
    endfunction

    // Reference: accepted samples in order, each tagged with the CE-cycle it entered.
    typedef struct { logic [7:0] op; longint a, b, d, c; int n; } samp_t;
    samp_t       hist[$];
    int          rd [NI];
    int          mcnt [NI];
    int          cen;
    logic [47:0] mp [NI];
    bit          mv [NI], mad [NI], mco [NI], mof [NI];

    task automatic model_reset();
        hist.delete();
        cen = 0;
        for (int i = 0; i < NI; i++) begin
            rd[i] = 0; mcnt[i] = 0; mp[i] = '0;
            mv[i] = 0; mad[i] = 0; mco[i] = 0; mof[i] = 0;
        end
    endtask

    task automatic model_apply(int i, samp_t s);
        longint bp, m, fb, x, z, r, pv, zu, xu, cin;
        bit ovf;
        bp = s.b;
        if (s.op[4]) bp = s.op[6] ? s.d - s.b : s.d + s.b;
        bp = wrap18(bp);
        m = s.a * bp;
        fb = (acc_of(i) > 0 && mcnt[i] == 0) ? 0 : sx48(mp[i]);
        case (s.op[1:0])
            2'd0: x = 0;
            2'd1: x = m;
            2'd2: x = fb;
            default: x = ((s.a & 64'h3FFFF) << 18) | (bp & 64'h3FFFF);
        endcase
        case (s.op[3:2])
            2'd0: z = 0;
            2'd1: z = sx48(pcin);
            2'd2: z = fb;
            default: z = s.c;
        endcase
        cin = s.op[5] ? 1 : 0;
        r = s.op[7] ? z - (x + cin) : z + x + cin;
        ovf = (r > MAXV) || (r < MINV);
        pv = (sat_of(i) != 0 && ovf) ? ((r < 0) ? MINV : MAXV) : r;
        mp[i] = pv[47:0];
        zu = z & MASK48;
        xu = x & MASK48;
        mco[i] = s.op[7] ? (zu < xu + cin) : (((zu + xu + cin) >> 48) != 0);
        mof[i] = ovf;
        mv[i] = 1;
        if (acc_of(i) > 0) begin
            mad[i] = (mcnt[i] == acc_of(i) - 1);
            mcnt[i] = mad[i] ? 0 : mcnt[i] + 1;
        end else begin
            mad[i] = 0;
        end
    endtask

    task automatic model_edge();
        samp_t s;
        if (rst) begin
            model_reset();
        end else if (ce) begin
            cen++;
            for (int i = 0; i < NI; i++) begin
                if (rd[i] < hist.size() && hist[rd[i]].n + lat_of(i) - 1 == cen) begin
                    model_apply(i, hist[rd[i]]);
                    rd[i]++;
                end else begin
                    mv[i] = 0;
                    mad[i] = 0;
                end
            end
            if (in_valid) begin
                s.op = opmode; s.a = sx18(a); s.b = sx18(b); s.d = sx18(d);
                s.c = sx48(c); s.n = cen;
                hist.push_back(s);
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_p%0d", ph, i),     64'(p_o[i]),  64'(mp[i]));
            check($sformatf("%s_pcout%0d", ph, i), 64'(pc_o[i]), 64'(mp[i]));
            check($sformatf("%s_valid%0d", ph, i), 64'(ov_o[i]), 64'(mv[i]));
            check($sformatf("%s_done%0d", ph, i),  64'(ad_o[i]), 64'(mad[i]));
            check($sformatf("%s_cout%0d", ph, i),  64'(co_o[i]), 64'(mco[i]));
            check($sformatf("%s_ovf%0d", ph, i),   64'(of_o[i]), 64'(mof[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [17:0] aa,
                         input logic [17:0] bb, input logic [17:0] dd, input logic [47:0] cc);
        in_valid = v; opmode = op; a = aa; b = bb; d = dd; c = cc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat0, lat2, ndone;
        logic [47:0] dp [2];
        logic [8:0] vpat, cpat, exp0, exp2;

        model_reset();
        do_reset();
        for (int i = 0; i < NI; i++) begin
            check("reset_p", 64'(p_o[i]), 64'd0);
            check("reset_valid", 64'(ov_o[i]), 64'd0);
        end
        ce = 1'b1;

        // Single-sample latency and product
        lat0 = -1; lat2 = -1;
        drive(1'b1, 8'h01, 18'd3, 18'd5, 18'd0, 48'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) in_valid = 1'b0;
            if (ov_o[0] && lat0 < 0) lat0 = k;
            if (ov_o[2] && lat2 < 0) lat2 = k;
        end
        check("t1_lat0", 64'(lat0), 64'd4);
        check("t1_lat2", 64'(lat2), 64'd2);
        check("t1_p", 64'(p_o[0]), 64'd15);

        // Pre-adder subtract then add
        drive(1'b1, 8'h51, 18'h3FFFE, 18'd4, 18'd10, 48'd0);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("t2_sub", 64'(p_o[0]), 64'h0000_FFFF_FFFF_FFF4);
        check("t2_sub_u2", 64'(p_o[2]), 64'h0000_FFFF_FFFF_FFF4);
        drive(1'b1, 8'h11, 18'h3FFFE, 18'd4, 18'd10, 48'd0);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("t2_add", 64'(p_o[0]), 64'h0000_FFFF_FFFF_FFE4);

        // Auto-dump over blocks of four
        do_reset();
        ndone = 0; dp[0] = '0; dp[1] = '0;
        for (int k = 1; k <= 14; k++) begin
            if (k <= 8) drive(1'b1, 8'h09, 18'd1, 18'(k), 18'd0, 48'd0);
            else in_valid = 1'b0;
            step();
            if (ad_o[1]) begin
                if (ndone < 2) dp[ndone] = p_o[1];
                ndone++;
            end
        end
        check("t3_ndone", 64'(ndone), 64'd2);
        check("t3_dump1", 64'(dp[0]), 64'd10);
        check("t3_dump2", 64'(dp[1]), 64'd26);
        check("t3_free", 64'(p_o[0]), 64'd36);
        check("t3_len1", 64'(p_o[2]), 64'd8);

        // Overflow: clamp vs wrap
        drive(1'b1, 8'h0D, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("t4_sat_p", 64'(p_o[1]), 64'h0000_7FFF_FFFF_FFFF);
        check("t4_sat_ovf", 64'(of_o[1]), 64'd1);
        check("t4_wrap_p", 64'(p_o[0]), 64'h0000_8000_0000_0000);
        check("t4_wrap_ovf", 64'(of_o[0]), 64'd1);

        // Bubbles with a two-cycle CE stall
        do_reset();
        vpat = 9'h01D; cpat = 9'h1E7; exp0 = 9'h0A0; exp2 = 9'h022;
        for (int k = 0; k < 9; k++) begin
            drive(vpat[k], 8'h01, 18'(k + 2), 18'd3, 18'd0, 48'd0);
            ce = cpat[k];
            step();
            check("t5_valid0", 64'(ov_o[0]), 64'(exp0[k]));
            check("t5_valid2", 64'(ov_o[2]), 64'(exp2[k]));
        end
        ce = 1'b1;
        in_valid = 1'b0;

        // Asynchronous reset with samples in flight
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            if (k <= 3) drive(1'b1, 8'h09, 18'd7, 18'd9, 18'd0, 48'd0);
            else in_valid = 1'b0;
            step();
        end
        check("t6_pre", 64'(p_o[0]), 64'd63);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            check("t6_p", 64'(p_o[i]), 64'd0);
            check("t6_pcout", 64'(pc_o[i]), 64'd0);
            check("t6_valid", 64'(ov_o[i]), 64'd0);
            check("t6_done", 64'(ad_o[i]), 64'd0);
            check("t6_cout", 64'(co_o[i]), 64'd0);
            check("t6_ovf", 64'(of_o[i]), 64'd0);
        end
        step();
        #2;
        rst = 1'b0;
        repeat (8) begin
            step();
            for (int i = 0; i < NI; i++) check("t6_idle", 64'(ov_o[i]), 64'd0);
        end

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            ce       = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            opmode   = 8'($urandom());
            a        = 18'($urandom());
            b        = 18'($urandom());
            d        = 18'($urandom());
            c        = 48'({$urandom(), $urandom()});
            pcin     = 48'({$urandom(), $urandom()});
            carryin  = 1'($urandom());
            step();
        end
        ce = 1'b1;
        in_valid = 1'b0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
